mem_port_arbiter: RTL and testbench

- Shares the single-port 32x8 data/instruction memory between three requesters: instruction fetch (port 0), stack datapath push/pop (port 1), and loader/debug (port 2).
- Performs round-robin arbitration, with an optional bounded lock so one requester can run an atomic pop-modify-push sequence.
- Drives the memory's address, writedata, writemem and readmem inputs.
- Returns registered read data to the requester that issued the read.

---
 rtl/mem_port_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction
// fetch (port 0), the stack datapath (port 1) and the loader/debug port
// (port 2). A requester may take a bounded lock to run an atomic
// pop-modify-push sequence. Read data is registered per port.
module mem_port_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        req,
    input  logic [2:0]        we,
    input  logic [2:0]        lock,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [DATA_W-1:0] wdata2,
    output logic [2:0]        gnt,
    output logic [2:0]        rvalid,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_writemem,
    output logic              mem_readmem,
    input  logic [DATA_W-1:0] mem_readmem_out
);

    localparam logic [3:0] LOCK_MAX_C = 4'(LOCK_MAX);

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [1:0]        r_rr_ptr;
    logic [1:0]        w_rr_ptr_nx;
    logic [1:0]        r_owner;
    logic [1:0]        w_owner_nx;
    logic [3:0]        r_lock_cnt;
    logic [3:0]        w_lock_cnt_nx;
    logic [3:0]        w_lock_cnt_inc;
    logic [2:0]        r_rvalid;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic [DATA_W-1:0] r_rdata2;

    logic [1:0]        w_cand1;
    logic [1:0]        w_cand2;
    logic [1:0]        w_win;
    logic              w_win_vld;
    logic              w_grant;
    logic [2:0]        w_gnt;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    // Successor of a port index in the ring 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign w_cand1        = next_port(r_rr_ptr);
    assign w_cand2        = next_port(w_cand1);
    assign w_lock_cnt_inc = r_lock_cnt + 4'd1;

    // Pick the winner: rotating priority in ARB, only the owner in LOCKED.
    always_comb begin
        w_win     = 2'd0;
        w_win_vld = 1'b0;
        if (r_state == ST_ARB) begin
            if (req[w_cand1]) begin
                w_win     = w_cand1;
                w_win_vld = 1'b1;
            end else if (req[w_cand2]) begin
                w_win     = w_cand2;
                w_win_vld = 1'b1;
            end else if (req[r_rr_ptr]) begin
                w_win     = r_rr_ptr;
                w_win_vld = 1'b1;
            end
        end else if (req[r_owner]) begin
            w_win     = r_owner;
            w_win_vld = 1'b1;
        end
    end

    // No grant is issued while reset is being applied.
    assign w_grant = w_win_vld & ~rst;
    assign w_gnt   = w_grant ? (3'b001 << w_win) : 3'b000;
    assign gnt     = w_gnt;

    // Route the winner's address and write data toward the memory.
    always_comb begin
        w_sel_addr  = addr2;
        w_sel_wdata = wdata2;
        case (w_win)
            2'd0: begin
                w_sel_addr  = addr0;
                w_sel_wdata = wdata0;
            end
            2'd1: begin
                w_sel_addr  = addr1;
                w_sel_wdata = wdata1;
            end
            default: begin
                w_sel_addr  = addr2;
                w_sel_wdata = wdata2;
            end
        endcase
    end

    // Memory is driven only in a grant cycle; otherwise everything is zero.
    assign mem_address   = w_grant ? w_sel_addr : '0;
    assign mem_writedata = w_grant ? w_sel_wdata : '0;
    assign mem_writemem  = w_grant & we[w_win];
    assign mem_readmem   = w_grant & ~we[w_win];

    // Next-state logic for arbitration pointer, lock ownership and lock count.
    always_comb begin
        w_state_nx    = r_state;
        w_rr_ptr_nx   = r_rr_ptr;
        w_owner_nx    = r_owner;
        w_lock_cnt_nx = r_lock_cnt;
        case (r_state)
            ST_ARB: begin
                if (w_grant) begin
                    w_rr_ptr_nx = w_win;
                    if (lock[w_win]) begin
                        w_state_nx    = ST_LOCKED;
                        w_owner_nx    = w_win;
                        w_lock_cnt_nx = 4'd1;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_grant) begin
                    w_lock_cnt_nx = w_lock_cnt_inc;
                end
                // Release on lock drop or when this grant exhausts the budget;
                // the old owner then has lowest priority.
                if (!lock[r_owner] || (w_grant && (w_lock_cnt_inc == LOCK_MAX_C))) begin
                    w_state_nx    = ST_ARB;
                    w_rr_ptr_nx   = r_owner;
                    w_lock_cnt_nx = 4'd0;
                end
            end
            default: begin
                w_state_nx = ST_ARB;
            end
        endcase
    end

    // Arbitration state register; reset abandons any lock in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_ARB;
            r_rr_ptr   <= 2'd2;
            r_owner    <= 2'd0;
            r_lock_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_nx;
            r_rr_ptr   <= w_rr_ptr_nx;
            r_owner    <= w_owner_nx;
            r_lock_cnt <= w_lock_cnt_nx;
        end
    end

    // Capture read data for the granted reader and pulse its rvalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 3'b000;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_rdata2 <= '0;
        end else begin
            r_rvalid <= w_gnt & ~we;
            if (w_gnt[0] && !we[0]) r_rdata0 <= mem_readmem_out;
            if (w_gnt[1] && !we[1]) r_rdata1 <= mem_readmem_out;
            if (w_gnt[2] && !we[2]) r_rdata2 <= mem_readmem_out;
        end
    end

    assign rvalid = r_rvalid;
    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;
    assign rdata2 = r_rdata2;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a small 32x8 memory model.
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req, we, lock;
    logic [4:0] addr0, addr1, addr2;
    logic [7:0] wdata0, wdata1, wdata2;
    logic [2:0] gnt, rvalid;
    logic [7:0] rdata0, rdata1, rdata2;
    logic [4:0] mem_address;
    logic [7:0] mem_writedata;
    logic       mem_writemem, mem_readmem;
    logic [7:0] mem_readmem_out;

    logic [7:0] M [32];
    logic       pl_en;
    logic [4:0] pl_addr;
    logic [7:0] pl_data;

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter #(.ADDR_W(5), .DATA_W(8), .LOCK_MAX(4)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .gnt(gnt), .rvalid(rvalid),
        .rdata0(rdata0), .rdata1(rdata1), .rdata2(rdata2),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_writemem(mem_writemem), .mem_readmem(mem_readmem),
        .mem_readmem_out(mem_readmem_out)
    );

    always #5 clk = ~clk;

    // Single-port memory: asynchronous read, write at posedge.
    always @(posedge clk) begin
        if (pl_en) M[pl_addr] <= pl_data;
        else if (mem_writemem) M[mem_address] <= mem_writedata;
    end
    assign mem_readmem_out = M[mem_address];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 3'b000; lock = 3'b000; we = 3'b000;
        tick();
        rst = 1'b0;
    endtask

    task automatic preload(input logic [4:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 3'b111; we = 3'b000; lock = 3'b000;
        #1;
        if (gnt !== 3'b000) begin n_err++; $display("FAIL rst_gnt: got %b want 000", gnt); end
        n_vec++;
        if ({mem_writemem, mem_readmem} !== 2'b00) begin n_err++; $display("FAIL rst_mem: got %b want 00", {mem_writemem, mem_readmem}); end
        n_vec++;
        tick();
        rst = 1'b0; req = 3'b000;
        #1;
        if (rvalid !== 3'b000) begin n_err++; $display("FAIL rst_rvalid: got %b want 000", rvalid); end
        n_vec++;
        if ({rdata0, rdata1, rdata2} !== 24'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 000000", {rdata0, rdata1, rdata2}); end
        n_vec++;
        if (mem_address !== 5'd0) begin n_err++; $display("FAIL idle_addr: got %0d want 0", mem_address); end
        n_vec++;
        tick();
    endtask

    task automatic test_round_robin();
        logic [2:0] eg [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        logic [4:0] ea [6] = '{5'd0, 5'd25, 5'd31, 5'd0, 5'd25, 5'd31};
        logic [7:0] exp_d;
        logic [7:0] got_d;
        do_reset();
        req = 3'b111; we = 3'b000; lock = 3'b000;
        addr0 = 5'd0; addr1 = 5'd25; addr2 = 5'd31;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (gnt !== eg[i]) begin n_err++; $display("FAIL rr_gnt c%0d: got %b want %b", i, gnt, eg[i]); end
            n_vec++;
            if (mem_address !== ea[i] || mem_readmem !== 1'b1) begin
                n_err++; $display("FAIL rr_mem c%0d: got addr %0d rd %b want addr %0d rd 1", i, mem_address, mem_readmem, ea[i]);
            end
            n_vec++;
            if (i > 0) begin
                if (rvalid !== eg[i-1]) begin n_err++; $display("FAIL rr_rvalid c%0d: got %b want %b", i, rvalid, eg[i-1]); end
                n_vec++;
                case (eg[i-1])
                    3'b001:  begin got_d = rdata0; exp_d = 8'h99; end
                    3'b010:  begin got_d = rdata1; exp_d = 8'h09; end
                    default: begin got_d = rdata2; exp_d = 8'h01; end
                endcase
                if (got_d !== exp_d) begin n_err++; $display("FAIL rr_rdata c%0d: got %h want %h", i, got_d, exp_d); end
                n_vec++;
            end
            tick();
        end
        req = 3'b000;
        #1;
        if (rvalid !== 3'b100) begin n_err++; $display("FAIL rr_last_rvalid: got %b want 100", rvalid); end
        n_vec++;
        if ({rdata0, rdata1, rdata2} !== 24'h990901) begin n_err++; $display("FAIL rr_rdata_all: got %h want 990901", {rdata0, rdata1, rdata2}); end
        n_vec++;
        tick();
        #1;
        if (rvalid !== 3'b000) begin n_err++; $display("FAIL rr_rvalid_pulse: got %b want 000", rvalid); end
        n_vec++;
    endtask

    task automatic test_write_then_read();
        do_reset();
        req = 3'b001; we = 3'b000; addr0 = 5'd0;
        #1;
        if (gnt !== 3'b001) begin n_err++; $display("FAIL wr_prime_gnt: got %b want 001", gnt); end
        n_vec++;
        tick();
        req = 3'b011; we = 3'b010; addr1 = 5'd30; wdata1 = 8'hF7; addr0 = 5'd30;
        #1;
        if (gnt !== 3'b010) begin n_err++; $display("FAIL wr_gnt: got %b want 010", gnt); end
        n_vec++;
        if ({mem_writemem, mem_readmem, mem_address, mem_writedata} !== {1'b1, 1'b0, 5'd30, 8'hF7}) begin
            n_err++; $display("FAIL wr_mem: got we %b rd %b a %0d d %h want 1 0 30 f7", mem_writemem, mem_readmem, mem_address, mem_writedata);
        end
        n_vec++;
        tick();
        req = 3'b001; we = 3'b000;
        #1;
        if (gnt !== 3'b001) begin n_err++; $display("FAIL rd_after_wr_gnt: got %b want 001", gnt); end
        n_vec++;
        if (rvalid !== 3'b000) begin n_err++; $display("FAIL wr_no_rvalid: got %b want 000", rvalid); end
        n_vec++;
        tick();
        req = 3'b000;
        #1;
        if (rvalid !== 3'b001 || rdata0 !== 8'hF7) begin n_err++; $display("FAIL rd_after_wr_data: got v %b d %h want 001 f7", rvalid, rdata0); end
        n_vec++;
        if ({gnt, mem_writemem, mem_readmem} !== 5'b0) begin n_err++; $display("FAIL wr_idle: got %b want 00000", {gnt, mem_writemem, mem_readmem}); end
        n_vec++;
        tick();
    endtask

    task automatic test_lock();
        logic [4:0] a1 [3] = '{5'd27, 5'd28, 5'd29};
        do_reset();
        req = 3'b001; we = 3'b000; addr0 = 5'd0;
        tick();
        for (int i = 0; i < 3; i++) begin
            req = 3'b011; addr1 = a1[i];
            we = (i == 2) ? 3'b010 : 3'b000;
            lock = (i == 2) ? 3'b000 : 3'b010;
            wdata1 = 8'hB2;
            #1;
            if (gnt !== 3'b010) begin n_err++; $display("FAIL lock_gnt a%0d: got %b want 010", i, gnt); end
            n_vec++;
            tick();
        end
        req = 3'b001; we = 3'b000; lock = 3'b000; addr0 = 5'd29;
        #1;
        if (gnt !== 3'b001) begin n_err++; $display("FAIL lock_release_gnt: got %b want 001", gnt); end
        n_vec++;
        tick();
        req = 3'b000;
        #1;
        if (rdata0 !== 8'hB2) begin n_err++; $display("FAIL lock_write_data: got %h want b2", rdata0); end
        n_vec++;
        tick();
    endtask

    task automatic test_forced_release();
        logic [2:0] eg [7] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b100, 3'b100};
        do_reset();
        req = 3'b001; we = 3'b000; addr0 = 5'd0;
        tick();
        req = 3'b101; lock = 3'b100; addr2 = 5'd31;
        for (int i = 0; i < 7; i++) begin
            #1;
            if (gnt !== eg[i]) begin n_err++; $display("FAIL forced_gnt c%0d: got %b want %b", i, gnt, eg[i]); end
            n_vec++;
            tick();
        end
        req = 3'b000; lock = 3'b000;
        tick();
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        req = 3'b010; lock = 3'b010; we = 3'b000; addr1 = 5'd25; addr0 = 5'd0;
        #1;
        if (gnt !== 3'b010) begin n_err++; $display("FAIL rml_gnt1: got %b want 010", gnt); end
        n_vec++;
        tick();
        #1;
        if (gnt !== 3'b010 || rvalid !== 3'b010 || rdata1 !== 8'h09) begin
            n_err++; $display("FAIL rml_gnt2: got g %b v %b d %h want 010 010 09", gnt, rvalid, rdata1);
        end
        n_vec++;
        tick();
        rst = 1'b1; req = 3'b011;
        #1;
        if (gnt !== 3'b000 || mem_readmem !== 1'b0) begin n_err++; $display("FAIL rml_rst_gnt: got g %b rd %b want 000 0", gnt, mem_readmem); end
        n_vec++;
        tick();
        rst = 1'b0;
        #1;
        if (rvalid !== 3'b000 || {rdata0, rdata1, rdata2} !== 24'h0) begin
            n_err++; $display("FAIL rml_clear: got v %b d %h want 000 000000", rvalid, {rdata0, rdata1, rdata2});
        end
        n_vec++;
        if (gnt !== 3'b001) begin n_err++; $display("FAIL rml_first_gnt: got %b want 001", gnt); end
        n_vec++;
        tick();
        req = 3'b000; lock = 3'b000;
        tick();
    endtask

    task automatic test_lock_gap();
        logic [2:0] rq [7] = '{3'b100, 3'b101, 3'b001, 3'b001, 3'b101, 3'b101, 3'b101};
        logic [2:0] eg [7] = '{3'b100, 3'b100, 3'b000, 3'b000, 3'b100, 3'b100, 3'b001};
        do_reset();
        we = 3'b000; lock = 3'b100; addr0 = 5'd0; addr2 = 5'd31;
        for (int i = 0; i < 7; i++) begin
            req = rq[i];
            #1;
            if (gnt !== eg[i]) begin n_err++; $display("FAIL gap_gnt c%0d: got %b want %b", i, gnt, eg[i]); end
            n_vec++;
            if (mem_readmem !== (eg[i] != 3'b000) || mem_writemem !== 1'b0) begin
                n_err++; $display("FAIL gap_mem c%0d: got rd %b wr %b want rd %b wr 0", i, mem_readmem, mem_writemem, eg[i] != 3'b000);
            end
            n_vec++;
            tick();
        end
        req = 3'b000; lock = 3'b000;
        tick();
    endtask

    initial begin
        rst = 1'b1; req = 3'b000; we = 3'b000; lock = 3'b000;
        addr0 = 5'd0; addr1 = 5'd0; addr2 = 5'd0;
        wdata0 = 8'h00; wdata1 = 8'h00; wdata2 = 8'h00;
        pl_en = 1'b0; pl_addr = 5'd0; pl_data = 8'h00;
        tick();
        preload(5'd0, 8'h99);
        preload(5'd25, 8'h09);
        preload(5'd31, 8'h01);
        test_reset();
        test_round_robin();
        test_write_then_read();
        test_lock();
        test_forced_release();
        test_reset_mid_lock();
        test_lock_gap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
